// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-slot instruction fetch stage.
// Holds the PC, issues one instruction-memory read per cycle when the
// output slot is free, and presents the fetched word to the D stage.
// Optional build macro FETCH_ADDR_EXC_EN: enables the fetch address check
// (misaligned or outside [IM_BASE, IM_BASE+IM_SIZE)), which emits an
// AdEL error slot and parks in ERR until redirected or reset.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        REDIR_EN,
    input  logic [31:0] REDIR_ADDR,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic        IM_ACK,
    input  logic [31:0] IM_RDATA,
    output logic        F_Valid,
    output logic [31:0] F_Instr,
    output logic [31:0] F_InstrAddr,
    output logic        F_ExcAdEL
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        slot_free;
    logic        addr_bad;

    // The slot can take a new instruction when empty or being consumed now.
    assign slot_free = !valid_q || !STALL;

`ifdef FETCH_ADDR_EXC_EN
    logic        exc_q, exc_d;
    logic [32:0] im_end;

    // 33-bit end so a window touching the top of the address space cannot wrap.
    assign im_end   = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
    assign addr_bad = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) ||
                      ({1'b0, pc_q} >= im_end);
    assign IM_ADDR   = pc_q;
    assign F_ExcAdEL = exc_q;
`else
    assign addr_bad  = 1'b0;
    assign IM_ADDR   = {pc_q[31:2], 2'b00};
    assign F_ExcAdEL = 1'b0;
`endif

    assign IM_REQ      = (state_q == RUN) && slot_free && !REDIR_EN && !addr_bad;
    assign F_Valid     = valid_q;
    assign F_Instr     = instr_q;
    assign F_InstrAddr = iaddr_q;

    // Next-state: redirect first, then per-state fetch / error / consume.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
`ifdef FETCH_ADDR_EXC_EN
        exc_d   = exc_q;
`endif
        if (REDIR_EN) begin
            // Flush the slot (even under STALL) and drop any same-cycle ack.
            state_d = RUN;
            pc_d    = REDIR_ADDR;
            valid_d = 1'b0;
            instr_d = 32'h0;
`ifdef FETCH_ADDR_EXC_EN
            exc_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (IM_REQ && IM_ACK) begin
                        valid_d = 1'b1;
                        instr_d = IM_RDATA;
                        iaddr_d = pc_q;
                        pc_d    = pc_q + 32'd4;
                    end else if (addr_bad && slot_free) begin
                        // Error slot carries a nop with the faulting PC.
                        state_d = ERR;
                        valid_d = 1'b1;
                        instr_d = 32'h0;
                        iaddr_d = pc_q;
`ifdef FETCH_ADDR_EXC_EN
                        exc_d   = 1'b1;
`endif
                    end else if (valid_q && !STALL) begin
                        valid_d = 1'b0;
                        instr_d = 32'h0;
                    end
                end
                default: begin
                    // ERR: drain the error slot, then stay empty.
                    if (valid_q && !STALL) begin
                        valid_d = 1'b0;
                        instr_d = 32'h0;
`ifdef FETCH_ADDR_EXC_EN
                        exc_d   = 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            iaddr_q <= 32'h0;
`ifdef FETCH_ADDR_EXC_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
`ifdef FETCH_ADDR_EXC_EN
            exc_q   <= exc_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Memory returns IM_ADDR ^ 0xA0000000.
// Each check compares one snapshot
// {IM_REQ, IM_ADDR, F_Valid, F_InstrAddr, F_Instr, F_ExcAdEL}.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        REDIR_EN = 1'b0;
    logic [31:0] REDIR_ADDR = 32'h0;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic        IM_ACK = 1'b1;
    logic [31:0] IM_RDATA;
    logic        F_Valid;
    logic [31:0] F_Instr;
    logic [31:0] F_InstrAddr;
    logic        F_ExcAdEL;

    int checks = 0;
    int errors = 0;

    logic [98:0] obs;
    logic [98:0] exp_v;

    always #5 clk = ~clk;

    assign IM_RDATA = IM_ADDR ^ 32'hA000_0000;
    assign obs = {IM_REQ, IM_ADDR, F_Valid, F_InstrAddr, F_Instr, F_ExcAdEL};

    if_fetch_unit dut (
        .clk(clk), .RESET(RESET), .STALL(STALL), .REDIR_EN(REDIR_EN),
        .REDIR_ADDR(REDIR_ADDR), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
        .IM_ACK(IM_ACK), .IM_RDATA(IM_RDATA), .F_Valid(F_Valid),
        .F_Instr(F_Instr), .F_InstrAddr(F_InstrAddr), .F_ExcAdEL(F_ExcAdEL)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IM_ACK = 1'b1;
        step(); step();
        exp_v = {1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_state got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_stream();
        RESET = 1'b0;
        step();  // IDLE -> RUN
        exp_v = {1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stream_first_req got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3004, 1'b1, 32'h3000, 32'hA000_3000, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stream_slot_3000 got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3008, 1'b1, 32'h3004, 32'hA000_3004, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stream_slot_3004 got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_stall();
        STALL = 1'b1;
        #1;
        exp_v = {1'b0, 32'h3008, 1'b1, 32'h3004, 32'hA000_3004, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, exp_v); end
        end
        STALL = 1'b0;
        step();
        exp_v = {1'b1, 32'h300C, 1'b1, 32'h3008, 32'hA000_3008, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_release got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3010, 1'b1, 32'h300C, 32'hA000_300C, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL stall_next got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_ack_wait();
        IM_ACK = 1'b0;
        step();
        exp_v = {1'b1, 32'h3010, 1'b0, 32'h300C, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ackwait_1 got=%h want=%h", obs, exp_v); end
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ackwait_2 got=%h want=%h", obs, exp_v); end
        IM_ACK = 1'b1;
        step();
        exp_v = {1'b1, 32'h3014, 1'b1, 32'h3010, 32'hA000_3010, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ackwait_slot got=%h want=%h", obs, exp_v); end
        step(); step(); step();  // slots 3014, 3018, 301C; PC now 3020
    endtask

    task automatic test_redirect();
        REDIR_EN = 1'b1; REDIR_ADDR = 32'h3100;
        #1;
        checks++;
        if (IM_REQ !== 1'b0) begin errors++; $display("FAIL redir_req_mask got=%b want=0", IM_REQ); end
        step();
        REDIR_EN = 1'b0;
        #1;
        exp_v = {1'b1, 32'h3100, 1'b0, 32'h301C, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_flush got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3104, 1'b1, 32'h3100, 32'hA000_3100, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_target got=%h want=%h", obs, exp_v); end
        // Redirect while stalled still flushes the slot.
        STALL = 1'b1; REDIR_EN = 1'b1; REDIR_ADDR = 32'h3200;
        step();
        REDIR_EN = 1'b0; STALL = 1'b0;
        #1;
        exp_v = {1'b1, 32'h3200, 1'b0, 32'h3100, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_stall_flush got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3204, 1'b1, 32'h3200, 32'hA000_3200, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL redir_stall_target got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_misaligned();
        REDIR_EN = 1'b1; REDIR_ADDR = 32'h3102;
        step();
        REDIR_EN = 1'b0;
        #1;
`ifdef FETCH_ADDR_EXC_EN
        exp_v = {1'b0, 32'h3102, 1'b0, 32'h3200, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL exc_noreq got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b0, 32'h3102, 1'b1, 32'h3102, 32'h0, 1'b1};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL exc_slot got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b0, 32'h3102, 1'b0, 32'h3102, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL exc_parked got=%h want=%h", obs, exp_v); end
`else
        exp_v = {1'b1, 32'h3100, 1'b0, 32'h3200, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL misalign_addr got=%h want=%h", obs, exp_v); end
        step();
        exp_v = {1'b1, 32'h3104, 1'b1, 32'h3102, 32'hA000_3100, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL misalign_slot got=%h want=%h", obs, exp_v); end
`endif
        REDIR_EN = 1'b1; REDIR_ADDR = 32'h3000;
        step();
        REDIR_EN = 1'b0;
        #1;
        exp_v = {1'b1, 32'h3000, 1'b0, F_InstrAddr, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL resume_3000 got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        REDIR_EN = 1'b1; REDIR_ADDR = 32'h3038;
        step();
        REDIR_EN = 1'b0;
        step(); step();  // slots 3038, 303C; PC now 3040
        exp_v = {1'b1, 32'h3040, 1'b1, 32'h303C, 32'hA000_303C, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pre_reset got=%h want=%h", obs, exp_v); end
        STALL = 1'b1; RESET = 1'b1; IM_ACK = 1'b1;
        step();
        exp_v = {1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL mid_reset got=%h want=%h", obs, exp_v); end
        RESET = 1'b0; STALL = 1'b0;
        step();
        exp_v = {1'b1, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL post_reset_req got=%h want=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ack_wait();
        test_redirect();
        test_misaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter IM_BASE, default 32'h0000_3000, lowest legal instruction address.
REQ-003 Parameter IM_SIZE, default 32'h0000_4000, legal instruction window size in bytes.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 STALL  input  1  downstream D-stage register not accepting this cycle.
REQ-007 REDIR_EN  input  1  redirect from D/E stage (branch, j, jal, jr).
REQ-008 REDIR_ADDR  input  32  redirect target.
REQ-009 IM_REQ  output  1  instruction memory read request.
REQ-010 IM_ADDR  output  32  word address presented with IM_REQ.
REQ-011 IM_ACK  input  1  memory returns IM_RDATA this cycle; may be high in the same cycle IM_REQ rises.
REQ-012 IM_RDATA  input  32  instruction word, valid only when IM_ACK=1.
REQ-013 F_Valid  output  1  F_Instr/F_InstrAddr hold a fetched slot.
REQ-014 F_Instr  output  32  fetched instruction; 32'h0 (nop) whenever F_Valid=0.
REQ-015 F_InstrAddr  output  32  address of F_Instr.
REQ-016 F_ExcAdEL  output  1  fetch address error on this slot (Configuration dependent).

Function
REQ-017 State machine SHALL have states IDLE, RUN, ERR; the state SHALL leave IDLE for RUN on the first posedge with RESET=0.
REQ-018 IM_REQ SHALL be (state==RUN) && (!F_Valid || !STALL) && !REDIR_EN, combinational; IM_ADDR SHALL equal the PC register.
REQ-019 A slot is consumed at any posedge with F_Valid=1 and STALL=0.
REQ-020 At a posedge with IM_REQ=1 and IM_ACK=1: F_Instr<=IM_RDATA, F_InstrAddr<=PC, F_Valid<=1, PC<=PC+4 (32-bit wrap), giving one instruction per cycle with zero-wait memory.
REQ-021 At a posedge with IM_REQ=1 and IM_ACK=0: PC and IM_ADDR SHALL be unchanged, and the request SHALL repeat next cycle.
REQ-022 At a posedge with consumption and no acknowledge: F_Valid<=0 and F_Instr<=0.
REQ-023 With F_Valid=1 and STALL=1, the outputs SHALL hold and IM_REQ SHALL be 0.
REQ-024 REDIR_EN=1 at a posedge SHALL take priority over everything except RESET: PC<=REDIR_ADDR, F_Valid<=0, F_Instr<=0, F_ExcAdEL<=0, state<=RUN (including exit from ERR); IM_ACK in that cycle is ignored.
REQ-025 REDIR_EN with STALL=1 SHALL still flush the output slot.

Reset
REQ-026 With RESET=1 at a posedge: state<=IDLE, PC<=PC_RESET, F_Valid<=0, F_Instr<=0, F_InstrAddr<=0, F_ExcAdEL<=0; IM_REQ is 0 during IDLE.
REQ-027 RESET SHALL override REDIR_EN, STALL and IM_ACK; reset during a pending request abandons that request.

Configuration
REQ-028 Macro FETCH_ADDR_EXC_EN defined: in RUN with (PC[1:0]!=0 or PC<IM_BASE or PC>=IM_BASE+IM_SIZE), IM_REQ SHALL be 0, and at the next posedge where the slot is free: F_Valid<=1, F_Instr<=0, F_InstrAddr<=PC, F_ExcAdEL<=1, state<=ERR; in ERR, IM_REQ SHALL be 0 and, after the error slot is consumed, F_Valid stays 0 until REDIR_EN or RESET.
REQ-029 Macro undefined: no range check, ERR unreachable, IM_ADDR SHALL be {PC[31:2],2'b00}, F_ExcAdEL SHALL be tied 0.

Verification
REQ-030 Reset release, IM_ACK tied 1, STALL=0 -> IM_ADDR 0x3000,0x3004,0x3008 on consecutive cycles; F_Valid first high one cycle after the first request.
REQ-031 STALL=1 for 3 cycles with slot 0x3004 held -> F_Instr/F_InstrAddr stable, IM_REQ=0; after release, 0x3008 follows with no gap or duplicate.
REQ-032 IM_ACK low 2 cycles at 0x3010 -> IM_ADDR held 0x3010, F_Valid drops after consumption, and the 0x3010 slot appears the cycle after the acknowledge.
REQ-033 REDIR_EN with REDIR_ADDR=0x3100 while IM_ACK=1 at 0x3020 -> the 0x3020 data is discarded, F_Valid=0, and the next request is 0x3100.
REQ-034 FETCH_ADDR_EXC_EN, redirect to 0x3102 -> one slot with F_Instr=0, F_InstrAddr=0x3102, F_ExcAdEL=1, IM_REQ stays 0, and redirect to 0x3000 resumes.
REQ-035 RESET asserted mid-stream at 0x3040 with STALL=1 -> next cycle all outputs 0 and PC=0x3000.
